// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM state encoding,
// next-PC select encoding and the redirect priority function.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W = 30;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    BUBBLE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_t;

  // jr beats jump beats branch; SEL_SEQ means no redirect requested.
  function automatic sel_t redirect_sel(input logic jr, input logic jump,
                                        input logic branch_taken);
    sel_t s;
    s = SEL_SEQ;
    if (jr) begin
      s = SEL_JR;
    end else if (jump) begin
      s = SEL_J;
    end else if (branch_taken) begin
      s = SEL_BR;
    end
    return s;
  endfunction

endpackage

// File: rtl/muxNby2to1.sv
// N-bit 2-to-1 multiplexer: y = sel ? in1 : in0.
module muxNby2to1 #(
  parameter int N = 30
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         sel,
  output logic [N-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/next_pc_select.sv
// Combinational next-PC word chain: (sequential/branch) -> jump -> jr,
// each stage a 2-to-1 mux so a later stage overrides an earlier one.
module next_pc_select
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_word,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [25:0]       jump_target,
  input  logic [ADDR_W-1:0] jr_word,
  input  sel_t              sel,
  output logic [ADDR_W-1:0] next_word
);

  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] jump_word;
  logic [ADDR_W-1:0] stage_br;
  logic [ADDR_W-1:0] stage_j;

  // Wraps naturally at the top of the word-address space.
  assign pc_seq    = pc_word + 1'b1;
  assign jump_word = {pc_seq[ADDR_W-1:26], jump_target};

  muxNby2to1 #(.N(ADDR_W)) u_mux_br (
    .in0 (pc_seq),
    .in1 (branch_target),
    .sel (sel == SEL_BR),
    .y   (stage_br)
  );

  muxNby2to1 #(.N(ADDR_W)) u_mux_j (
    .in0 (stage_br),
    .in1 (jump_word),
    .sel (sel == SEL_J),
    .y   (stage_j)
  );

  muxNby2to1 #(.N(ADDR_W)) u_mux_jr (
    .in0 (stage_j),
    .in1 (jr_word),
    .sel (sel == SEL_JR),
    .y   (next_word)
  );

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch controller: owns the PC word register, sequences fetch
// against imem readiness/stall and inserts a one-cycle bubble on redirects.
module pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_W       = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic [31:0]       jr_addr,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus4,
  output logic              fetch_valid,
  output logic              misalign,
  output state_t            fsm_state
);

  // Handshake: a fetch at pc_out is offered while fetch_valid=1 and is
  // consumed on a rising edge where imem_ready=1 and stall=0; otherwise the
  // same pc_out is re-offered. A redirect overrides both and drops the offer.

  state_t            state_q, state_next;
  logic [ADDR_W-1:0] pc_word, pc_next;
  logic              fetch_valid_q, misalign_q, misalign_next;
  logic [ADDR_W-1:0] sel_word;
  sel_t              sel;
  logic              redirect;

  assign sel      = redirect_sel(jr, jump, branch_taken);
  assign redirect = (sel != SEL_SEQ);

  next_pc_select #(.ADDR_W(ADDR_W)) u_next_pc_select (
    .pc_word       (pc_word),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_word       (jr_addr[ADDR_W+1:2]),
    .sel           (sel),
    .next_word     (sel_word)
  );

  always_comb begin
    state_next    = state_q;
    pc_next       = pc_word;
    misalign_next = 1'b0;
    case (state_q)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH, HOLD: begin
        if (redirect) begin
          pc_next       = sel_word;
          state_next    = BUBBLE;
          misalign_next = jr && (jr_addr[1:0] != 2'b00);
        end else if (imem_ready && !stall) begin
          pc_next    = sel_word;
          state_next = FETCH;
        end else begin
          state_next = HOLD;
        end
      end
      BUBBLE: begin
        // A redirect here reloads the target and keeps the bubble one more cycle.
        if (redirect) begin
          pc_next       = sel_word;
          state_next    = BUBBLE;
          misalign_next = jr && (jr_addr[1:0] != 2'b00);
        end else begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_word       <= RESET_VECTOR[ADDR_W+1:2];
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_next;
      pc_word       <= pc_next;
      fetch_valid_q <= (state_next == FETCH) || (state_next == HOLD);
      misalign_q    <= misalign_next;
    end
  end

  assign pc_out      = {pc_word, 2'b00};
  assign pc_plus4    = {pc_word, 2'b00} + 32'd4;
  assign fetch_valid = fetch_valid_q;
  assign misalign    = misalign_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: byte-address behavioural model, per-cycle compare,
// directed literal checks followed by randomized traffic.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [29:0] branch_target;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misalign;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state, in byte addresses and plain flags.
  logic [31:0] m_pc;
  bit m_boot, m_live, m_held, m_mis;

  pc_sequencer #(.RESET_VECTOR(RV), .ADDR_W(30)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .misalign      (misalign),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: outputs after this edge, from the rules in byte terms.
  always @(posedge clk) begin
    if (!reset) begin
      m_pc = {RV[31:2], 2'b00};
      m_boot = 1; m_live = 0; m_held = 0; m_mis = 0;
    end else begin
      m_mis = 0;
      if (!m_boot && (jr || jump || branch_taken)) begin
        if (jr) begin
          m_pc  = jr_addr & 32'hFFFF_FFFC;
          m_mis = (jr_addr % 4) != 0;
        end else if (jump) begin
          m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jump_target} * 4);
        end else begin
          m_pc = {2'b00, branch_target} * 4;
        end
        m_live = 0; m_held = 0;
      end else if (m_boot) begin
        m_boot = 0; m_live = 1; m_held = 0;
      end else if (!m_live) begin
        m_live = 1; m_held = 0;
      end else if (imem_ready && !stall) begin
        m_pc = m_pc + 32'd4; m_held = 0;
      end else begin
        m_held = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", pc_out, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_live});
      check("misalign", {31'd0, misalign}, {31'd0, m_mis});
      check("state", {30'd0, fsm_state},
            m_boot ? 32'd0 : (!m_live ? 32'd3 : (m_held ? 32'd2 : 32'd1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_redirects();
    branch_taken = 0; jump = 0; jr = 0;
  endtask

  task automatic lit(input string name, input logic [31:0] exp_pc, input bit exp_fv);
    check({name, "_pc"}, pc_out, exp_pc);
    check({name, "_fv"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
  endtask

  initial begin
    reset = 0; imem_ready = 1; stall = 0;
    branch_taken = 0; branch_target = '0;
    jump = 0; jump_target = '0; jr = 0; jr_addr = '0;
    @(negedge clk);
    tick();
    chk_en = 1;
    tick();
    lit("reset", 32'h40, 0);
    check("reset_state", {30'd0, fsm_state}, 32'd0);
    check("reset_mis", {31'd0, misalign}, 32'd0);

    reset = 1;
    tick(); lit("boot0", 32'h40, 1);
    tick(); lit("seq1", 32'h44, 1);
    tick(); lit("seq2", 32'h48, 1);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("stall_hold", 32'h48, 1);
    end
    stall = 0;
    tick(); lit("stall_rel", 32'h4C, 1);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("nrdy_hold", 32'h4C, 1);
    end
    imem_ready = 1;
    tick(); lit("nrdy_rel", 32'h50, 1);

    branch_taken = 1; branch_target = 30'h40;
    tick(); lit("br_to100", 32'h100, 0);
    clear_redirects();
    tick(); lit("at100", 32'h100, 1);

    branch_taken = 1; branch_target = 30'h80; stall = 1;
    tick(); lit("br_stall", 32'h200, 0);
    clear_redirects(); stall = 0;
    tick(); lit("br_live", 32'h200, 1);
    tick(); lit("br_next", 32'h204, 1);

    jr = 1; jr_addr = 32'h0000_1002; jump = 1; jump_target = 26'h5;
    branch_taken = 1; branch_target = 30'h7;
    tick(); lit("prio", 32'h1000, 0);
    check("prio_mis", {31'd0, misalign}, 32'd1);
    clear_redirects();
    tick(); lit("prio_live", 32'h1000, 1);
    check("mis_once", {31'd0, misalign}, 32'd0);

    jr = 1; jr_addr = 32'hFFFF_FFFC;
    tick(); clear_redirects();
    tick(); lit("top", 32'hFFFF_FFFC, 1);
    check("top_plus4", pc_plus4, 32'h0);
    tick(); lit("wrap", 32'h0, 1);

    jr = 1; jr_addr = 32'h1000_0000;
    tick(); clear_redirects();
    tick(); lit("j_base", 32'h1000_0000, 1);
    jump = 1; jump_target = 26'h3;
    tick(); lit("jump", 32'h1000_000C, 0);
    clear_redirects();
    tick(); lit("jump_live", 32'h1000_000C, 1);

    branch_taken = 1; branch_target = 30'h10;
    tick(); lit("bub1", 32'h40, 0);
    branch_taken = 0; jr = 1; jr_addr = 32'h0000_1003;
    tick(); lit("bub2", 32'h1000, 0);
    clear_redirects(); reset = 0;
    tick(); lit("rst_bub", 32'h40, 0);
    check("rst_bub_mis", {31'd0, misalign}, 32'd0);
    check("rst_bub_state", {30'd0, fsm_state}, 32'd0);
    reset = 1;

    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 59) != 0);
      imem_ready    = ($urandom_range(0, 4) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      jr            = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jr_addr       = $urandom;
      jump_target   = 26'($urandom);
      branch_target = 30'($urandom);
      tick();
    end
    reset = 1;
    clear_redirects();
    tick();
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and drives the next-PC select chain of 30-bit word-address 2-to-1 muxes: sequential, branch, jump, register-jump.
- Sequences fetch against instruction-memory readiness and pipeline stall.
- Inserts a one-cycle bubble on every redirect.
- Sits between the decode/branch-resolution logic and the instruction memory address port.

Parameters:
- RESET_VECTOR, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] ignored.
- ADDR_W, 30, word-address width of the PC register and mux chain.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- imem_ready  input  1  instruction memory accepts the current fetch this cycle.
- stall  input  1  downstream pipeline cannot accept an instruction; hold PC.
- branch_taken  input  1  resolved conditional branch; redirect to branch_target.
- branch_target  input  30  word address of branch destination.
- jump  input  1  J/JAL redirect.
- jump_target  input  26  instruction index field.
- jr  input  1  JR/JALR redirect.
- jr_addr  input  32  register byte address.
- pc_out  output  32  byte address of current fetch, {pc_word, 2'b00}.
- pc_plus4  output  32  pc_out + 4, modulo 2^32.
- fetch_valid  output  1  pc_out is a live fetch request.
- misalign  output  1  one-cycle pulse: accepted jr with jr_addr[1:0] != 0.

Behaviour:
- Reset (reset==0 at a rising edge): pc_word <= RESET_VECTOR[31:2], state <= BOOT, fetch_valid=0, misalign=0. Reset mid-operation discards any pending redirect.
- States:
  - BOOT: fetch_valid=0; unconditionally -> FETCH next cycle. Redirect inputs ignored.
  - FETCH: fetch_valid=1.
  - HOLD: fetch_valid=1, same pc_out as previous cycle.
  - BUBBLE: fetch_valid=0.
- Redirect priority, sampled in FETCH, HOLD and BUBBLE: jr > jump > branch_taken. Lower-priority requests in the same cycle are dropped.
- Redirect targets:
  - jr: pc_word <= jr_addr[31:2]; misalign pulses next cycle if jr_addr[1:0] != 0; the address is still truncated and used.
  - jump: pc_word <= {pc_seq[29:26], jump_target}, where pc_seq = pc_word + 1.
  - branch: pc_word <= branch_target.
- Any redirect -> BUBBLE next cycle, regardless of stall or imem_ready; redirect beats stall.
- No redirect, FETCH or HOLD:
  - imem_ready && !stall: pc_word <= pc_seq; -> FETCH.
  - otherwise: pc_word held; -> HOLD.
- No redirect, BUBBLE: pc_word held; -> FETCH (bubble lasts exactly one cycle).
- pc_seq wraps: 30'h3FFF_FFFF + 1 = 0. pc_plus4 is combinational from the pc_word register.
- Latency: redirect asserted in cycle N gives pc_out = target in cycle N+1 with fetch_valid=0, and fetch_valid=1 at that target in N+2.
- Redirect while BUBBLE: new target loaded, BUBBLE extended one more cycle.
- All outputs registered except pc_plus4 (combinational from the register).

Decomposition:
- Shared package (fetch_pkg):
  - state encoding: BOOT=2'd0, FETCH=2'd1, HOLD=2'd2, BUBBLE=2'd3;
  - ADDR_W default;
  - redirect-select encoding: SEL_SEQ, SEL_BR, SEL_J, SEL_JR.
- One natural sub-module, next_pc_select: purely combinational. It chains three muxNby2to1 #(30) instances (seq/branch -> jump -> jr) under priority select and outputs the next pc_word.
- FSM and PC register stay in the top.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_0040, hold reset low 2 cycles, release, imem_ready=1 -> BOOT cycle fetch_valid=0; then pc_out 0x40, 0x44, 0x48 with fetch_valid=1.
- At pc_out=0x48 drive stall=1 for 3 cycles -> pc_out stays 0x48 with fetch_valid=1; stall=0 -> 0x4C. Repeat with imem_ready=0 and stall=0 -> same hold.
- At pc_out=0x100 assert branch_taken, branch_target=30'h80, with stall=1 the same cycle -> next cycle pc_out=0x200 with fetch_valid=0; following cycle fetch_valid=1 at 0x200.
- Same cycle assert jr (jr_addr=32'h0000_1002), jump, and branch_taken -> pc_out=0x1000, misalign pulses high exactly one cycle, bubble inserted.
- pc_word=30'h3FFF_FFFF, i.e. pc_out=0xFFFF_FFFC, advance -> pc_out=0x0000_0000. Jump with jump_target=26'h3 from pc_out=0x1000_0000 -> pc_out=0x1000_000C.
- Redirect in BUBBLE, then reset asserted during the following BUBBLE -> pc_out=RESET_VECTOR, fetch_valid=0, misalign=0, state BOOT.
